// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: byte-wide CPU register window and start/done/ack sequencer for the FPU core.
module fpu_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TMR_W          = 13
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic [3:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        irq,
    output logic        core_start,
    output logic [3:0]  core_op,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic [31:0] core_result,
    input  logic        core_done,
    output logic        core_ack
);

    localparam logic [3:0]       ADDR_CMD    = 4'd12;
    localparam logic [3:0]       ADDR_STATUS = 4'd13;
    localparam logic [3:0]       ADDR_CTRL   = 4'd14;
    localparam logic [3:0]       OP_MAX      = 4'hD;
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        main_idle_st,
        main_wait_st,
        main_finish_st,
        main_wait_ack_st
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        res_q, res_d;
    logic [3:0]         op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               irq_en_q, irq_en_d;
    logic               start_q, start_d;
    logic               ack_q, ack_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;

    logic               wr_en;
    logic               rd_status;
    logic               cmd_wr;
    logic               abort;
    logic               set_ev;

    assign wr_en     = cs & wr;
    assign rd_status = cs & rd & (addr == ADDR_STATUS);
    assign cmd_wr    = wr_en & (addr == ADDR_CMD);
    assign abort     = wr_en & (addr == ADDR_CTRL) & din[1];

    // State and register file, cleared asynchronously by arst.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= main_idle_st;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_en_q <= 1'b0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_en_q <= irq_en_d;
            start_q  <= start_d;
            ack_q    <= ack_d;
            tmr_q    <= tmr_d;
        end
    end

    // Next-state: bus writes, sequencing, timeout/abort and clear-on-read with set priority.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        irq_en_d = irq_en_q;
        start_d  = 1'b0;
        ack_d    = ack_q;
        tmr_d    = tmr_q;
        set_ev   = 1'b0;

        if (wr_en && !busy_q) begin
            if (addr[3:2] == 2'd0) begin
                a_d[{addr[1:0], 3'b000} +: 8] = din;
            end else if (addr[3:2] == 2'd1) begin
                b_d[{addr[1:0], 3'b000} +: 8] = din;
            end
        end
        if (wr_en && (addr == ADDR_CTRL)) begin
            irq_en_d = din[0];
        end

        case (state_q)
            main_idle_st: begin
                if (cmd_wr) begin
                    if (din[3:0] <= OP_MAX) begin
                        op_d    = din[3:0];
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        start_d = 1'b1;
                        tmr_d   = '0;
                        state_d = main_wait_st;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        set_ev  = 1'b1;
                    end
                end
            end
            main_wait_st: begin
                if (core_done) begin
                    state_d = main_finish_st;
                end else if (abort || (tmr_q == TMR_LAST)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    set_ev  = 1'b1;
                    state_d = main_idle_st;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            main_finish_st: begin
                res_d   = core_result;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ack_d   = 1'b1;
                set_ev  = 1'b1;
                state_d = main_wait_ack_st;
            end
            main_wait_ack_st: begin
                if (!core_done) begin
                    ack_d   = 1'b0;
                    state_d = main_idle_st;
                end
            end
            default: state_d = main_idle_st;
        endcase

        if (rd_status && !set_ev) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
    end

    // Read mux; busy bit also covers the non-idle tail so software waits for idle.
    always_comb begin
        dout = '0;
        if (cs && rd) begin
            case (addr[3:2])
                2'd0: dout = a_q[{addr[1:0], 3'b000} +: 8];
                2'd1: dout = b_q[{addr[1:0], 3'b000} +: 8];
                2'd2: dout = res_q[{addr[1:0], 3'b000} +: 8];
                default: begin
                    case (addr[1:0])
                        2'd0:    dout = {4'b0000, op_q};
                        2'd1:    dout = {5'b00000, err_q, done_q, busy_q | (state_q != main_idle_st)};
                        2'd2:    dout = {7'b0000000, irq_en_q};
                        default: dout = '0;
                    endcase
                end
            endcase
        end
    end

    assign irq        = done_q & irq_en_q;
    assign core_start = start_q;
    assign core_ack   = ack_q;
    assign core_op    = op_q;
    assign core_a     = a_q;
    assign core_b     = b_q;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb_fpu_seq_ctrl: directed bench with a transaction-level model and a per-cycle output compare.
module tb_fpu_seq_ctrl;

    localparam int TMO    = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_FIN  = 2;
    localparam int M_ACK  = 3;

    logic        clk;
    logic        arst;
    logic        cs;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        irq;
    logic        core_start;
    logic [3:0]  core_op;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [31:0] core_result_t;
    logic        core_done_t;
    logic        core_ack;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    fpu_seq_ctrl #(.TIMEOUT_CYCLES(TMO), .TMR_W(13)) dut (
        .clk(clk), .arst(arst), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din),
        .dout(dout), .irq(irq), .core_start(core_start), .core_op(core_op),
        .core_a(core_a), .core_b(core_b), .core_result(core_result_t),
        .core_done(core_done_t), .core_ack(core_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core stand-in: latency after start, then holds done for extra cycles once ack is seen.
    bit          core_resp_en = 1'b1;
    int          core_lat     = 5;
    int          core_hold    = 0;
    logic [31:0] core_val     = 32'h0;
    bit          cm_pend;
    int          cm_cnt;
    int          cm_hold;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            core_done_t   <= 1'b0;
            core_result_t <= 32'h0;
            cm_pend       <= 1'b0;
            cm_cnt        <= 0;
            cm_hold       <= 0;
        end else if (core_done_t) begin
            if (core_ack) begin
                if (cm_hold == 0) core_done_t <= 1'b0;
                else              cm_hold <= cm_hold - 1;
            end
        end else if (cm_pend) begin
            if (cm_cnt <= 1) begin
                core_done_t   <= 1'b1;
                core_result_t <= core_val;
                cm_pend       <= 1'b0;
                cm_hold       <= core_hold;
            end else begin
                cm_cnt <= cm_cnt - 1;
            end
        end else if (core_start && core_resp_en) begin
            cm_pend <= 1'b1;
            cm_cnt  <= core_lat;
        end
    end

    // Behavioural model: register window plus the lifecycle of one operation.
    typedef struct {
        int          mode;
        int          cnt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  op;
        logic        done;
        logic        err;
        logic        irq_en;
        logic        start;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t s, logic c, logic w_i, logic r_i,
                                          logic [3:0] ad, logic [7:0] d,
                                          logic cdone, logic [31:0] cres);
        model_t n     = s;
        logic   w     = c & w_i;
        logic   busy  = (s.mode == M_RUN) || (s.mode == M_FIN);
        logic   abort = w && (ad == 4'd14) && d[1];
        logic   setv  = 1'b0;
        int     ai    = int'(ad);
        n.start = 1'b0;
        if (w && !busy && ai < 4)            n.a[8*ai +: 8] = d;
        if (w && !busy && ai >= 4 && ai < 8) n.b[8*(ai-4) +: 8] = d;
        if (w && ai == 14)                   n.irq_en = d[0];
        if (s.mode == M_IDLE) begin
            if (w && ai == 12) begin
                if (d[3:0] <= 4'hD) begin
                    n.op = d[3:0]; n.mode = M_RUN; n.cnt = 0;
                    n.done = 1'b0; n.err = 1'b0; n.start = 1'b1;
                end else begin
                    n.done = 1'b1; n.err = 1'b1; setv = 1'b1;
                end
            end
        end else if (s.mode == M_RUN) begin
            if (cdone) n.mode = M_FIN;
            else if (abort || s.cnt == TMO - 1) begin
                n.done = 1'b1; n.err = 1'b1; setv = 1'b1; n.mode = M_IDLE;
            end else n.cnt = s.cnt + 1;
        end else if (s.mode == M_FIN) begin
            n.res = cres; n.done = 1'b1; setv = 1'b1; n.mode = M_ACK;
        end else begin
            if (!cdone) n.mode = M_IDLE;
        end
        if (c && r_i && ai == 13 && !setv) begin
            n.done = 1'b0; n.err = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [7:0] model_read(model_t s, logic c, logic r_i, logic [3:0] ad);
        int ai = int'(ad);
        if (!(c && r_i)) return 8'h00;
        if (ai < 4)   return s.a[8*ai +: 8];
        if (ai < 8)   return s.b[8*(ai-4) +: 8];
        if (ai < 12)  return s.res[8*(ai-8) +: 8];
        if (ai == 12) return {4'h0, s.op};
        if (ai == 13) return {5'b0, s.err, s.done, logic'(s.mode != M_IDLE)};
        if (ai == 14) return {7'b0, s.irq_en};
        return 8'h00;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) m <= '{default: 0};
        else      m <= model_step(m, cs, wr, rd, addr, din, core_done_t, core_result_t);
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cmp_dout",  32'(dout),       32'(model_read(m, cs, rd, addr)));
            chk("cmp_irq",   32'(irq),        32'(m.done & m.irq_en));
            chk("cmp_start", 32'(core_start), 32'(m.start));
            chk("cmp_ack",   32'(core_ack),   32'(m.mode == M_ACK));
            chk("cmp_op",    32'(core_op),    32'(m.op));
            chk("cmp_a",     core_a,          m.a);
            chk("cmp_b",     core_b,          m.b);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; din = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1;
        chk(name, 32'(dout), 32'(exp));
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_ack_lvl(input logic lvl, input int max, input string name);
        for (int i = 0; i < max && core_ack !== lvl; i++) idle(1);
        chk(name, 32'(core_ack), 32'(lvl));
    endtask

    task automatic wait_core_done(input int max, input string name);
        for (int i = 0; i < max && core_done_t !== 1'b1; i++) idle(1);
        chk(name, 32'(core_done_t), 32'h1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        arst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'h0; din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_start", 32'(core_start), 32'h0);
        bus_read(4'd13, 8'h00, "rst_status");

        // Add: 1.5 + 2.25
        bus_write(4'd0, 8'h00); bus_write(4'd1, 8'h00); bus_write(4'd2, 8'hC0); bus_write(4'd3, 8'h3F);
        bus_write(4'd4, 8'h00); bus_write(4'd5, 8'h00); bus_write(4'd6, 8'h10); bus_write(4'd7, 8'h40);
        chk("add_core_a", core_a, 32'h3FC00000);
        chk("add_core_b", core_b, 32'h40100000);
        core_resp_en = 1'b1; core_lat = 5; core_hold = 0; core_val = 32'h40700000;
        bus_write(4'd12, 8'h00);
        chk("add_start_hi", 32'(core_start), 32'h1);
        chk("add_op", 32'(core_op), 32'h0);
        idle(1);
        chk("add_start_lo", 32'(core_start), 32'h0);
        idle(20);
        bus_read(4'd13, 8'h02, "add_status_done");
        bus_read(4'd8,  8'h00, "add_res0");
        bus_read(4'd9,  8'h00, "add_res1");
        bus_read(4'd10, 8'h70, "add_res2");
        bus_read(4'd11, 8'h40, "add_res3");
        bus_read(4'd13, 8'h00, "add_status_clr");

        // Handshake with held core_done, and a CMD write ignored during the ack tail
        core_lat = 2; core_hold = 3; core_val = 32'hC0000000;
        bus_write(4'd12, 8'h01);
        wait_ack_lvl(1'b1, 30, "hs_ack_rise");
        bus_read(4'd13, 8'h03, "hs_status_busy");
        bus_write(4'd12, 8'h03);
        chk("hs_no_restart", 32'(core_start), 32'h0);
        chk("hs_ack_held", 32'(core_ack), 32'h1);
        wait_ack_lvl(1'b0, 20, "hs_ack_fall");
        bus_read(4'd13, 8'h00, "hs_status_idle");
        bus_read(4'd12, 8'h01, "hs_op_kept");
        bus_read(4'd11, 8'hC0, "hs_res3");

        // Invalid opcode with interrupt enabled
        bus_write(4'd14, 8'h01);
        bus_write(4'd12, 8'h0F);
        chk("inv_no_start", 32'(core_start), 32'h0);
        chk("inv_irq", 32'(irq), 32'h1);
        idle(2);
        chk("inv_irq_held", 32'(irq), 32'h1);
        bus_read(4'd13, 8'h06, "inv_status");
        chk("inv_irq_clr", 32'(irq), 32'h0);
        bus_read(4'd12, 8'h01, "inv_op_kept");

        // Timeout after exactly TMO edges; A write while busy ignored
        core_resp_en = 1'b0;
        bus_write(4'd12, 8'h02);
        bus_write(4'd0, 8'hAA);
        idle(14);
        bus_read(4'd13, 8'h01, "tmo_status_before");
        bus_read(4'd13, 8'h06, "tmo_status_after");
        bus_read(4'd0, 8'h00, "tmo_a_kept");

        // Abort via CTRL
        bus_write(4'd12, 8'h04);
        idle(2);
        bus_write(4'd14, 8'h02);
        bus_read(4'd13, 8'h06, "abort_status");
        bus_read(4'd14, 8'h00, "abort_ctrl");

        // STATUS read collides with the finish edge: done must survive
        core_resp_en = 1'b1; core_lat = 3; core_hold = 0; core_val = 32'h12345678;
        bus_write(4'd12, 8'h03);
        wait_core_done(20, "col_core_done");
        idle(1);
        bus_read(4'd13, 8'h01, "col_status_during");
        wait_ack_lvl(1'b0, 20, "col_ack_fall");
        bus_read(4'd13, 8'h02, "col_done_kept");
        bus_read(4'd8, 8'h78, "col_res0");

        // Asynchronous reset in the middle of an operation
        core_resp_en = 1'b0;
        bus_write(4'd0, 8'h5A);
        bus_write(4'd12, 8'h05);
        chk("rst_pre_start", 32'(core_start), 32'h1);
        chk("rst_pre_a", core_a, 32'h3FC0005A);
        cs = 1'b1; rd = 1'b1; addr = 4'd12;
        #1;
        chk("rst_pre_dout", 32'(dout), 32'h05);
        arst = 1'b1;
        #1;
        chk("rst_async_start", 32'(core_start), 32'h0);
        chk("rst_async_ack", 32'(core_ack), 32'h0);
        chk("rst_async_a", core_a, 32'h0);
        chk("rst_async_b", core_b, 32'h0);
        chk("rst_async_op", 32'(core_op), 32'h0);
        chk("rst_async_dout", 32'(dout), 32'h0);
        chk("rst_async_irq", 32'(irq), 32'h0);
        @(negedge clk);
        #2;
        arst = 1'b0;
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0;
        bus_read(4'd0,  8'h00, "rst_a0");
        bus_read(4'd7,  8'h00, "rst_b3");
        bus_read(4'd11, 8'h00, "rst_res3");
        bus_read(4'd12, 8'h00, "rst_op");
        bus_read(4'd13, 8'h00, "rst_status_after");
        bus_read(4'd14, 8'h00, "rst_ctrl");
        idle(2);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
